seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/shift_add_mul.sv | 67 ++++++
 rtl/seq_alu.sv | 145 ++++++++++++++
 tb/tb_seq_alu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM states
// and bit positions inside the {N,Z,C,V} flag vector.
package alu_pkg;

   typedef enum logic [2:0] {
      RPASSA = 3'd0,
      RPASSB = 3'd1,
      RADD   = 3'd2,
      RSUB   = 3'd3,
      RMUL   = 3'd4,
      RAND   = 3'd5,
      ROR    = 3'd6,
      RXOR   = 3'd7
   } alu_func_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } alu_state_e;

   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned n x n multiplier, one multiplier bit per clock.
// done/prod are combinational: they flag the edge on which the product completes.
module shift_add_mul #(
   parameter int n = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] prod
);

   localparam int CW = $clog2(n + 1);
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   logic [2*n-1:0] acc_q, acc_d;
   logic [2*n-1:0] mcand_q, mcand_d;
   logic [n-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         acc_d    = '0;
         mcand_d  = {{n{1'b0}}, a};
         mplier_d = b;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (cnt_q == LAST) busy_d = 1'b0;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == LAST);
   // Next accumulator value, so the caller can register the product on the final edge.
   assign prod = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus an n-cycle
// shift-add multiply, with registered results and {N,Z,C,V} flags.
module seq_alu
   import alu_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] in1,
   input  logic [n-1:0] in2,
   input  logic [2:0]   alu_func,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [n-1:0] out,
   output logic [n-1:0] out_hi,
   output logic [3:0]   flags,
   output logic         out_valid
);

   // Handshake: an op is taken on a rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE and requests seen while low are dropped.

   alu_state_e     state_q, state_d;
   logic [n-1:0]   out_q, out_d;
   logic [n-1:0]   out_hi_q, out_hi_d;
   logic [3:0]     flags_q, flags_d;
   logic           out_valid_q, out_valid_d;

   alu_func_e      func;
   logic           accept;
   logic           mul_start, mul_busy, mul_done;
   logic [2*n-1:0] mul_prod;

   logic [n:0]     sum_w, diff_w;
   logic [n-1:0]   res;
   logic           res_c, res_v;

   assign func      = alu_func_e'(alu_func);
   assign in_ready  = (state_q == S_IDLE);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (func == RMUL);

   shift_add_mul #(.n(n)) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (mul_start),
      .a     (in1),
      .b     (in2),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         out_q       <= '0;
         out_hi_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_hi_q    <= out_hi_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum_w  = {1'b0, in1} + {1'b0, in2};
   assign diff_w = {1'b0, in1} - {1'b0, in2};

   // Single-cycle datapath; C/V stay zero for logic, pass and unknown codes.
   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (func)
         RPASSA: res = in1;
         RPASSB: res = in2;
         RADD: begin
            res   = sum_w[n-1:0];
            res_c = sum_w[n];
            res_v = (in1[n-1] == in2[n-1]) && (sum_w[n-1] != in1[n-1]);
         end
         RSUB: begin
            res   = diff_w[n-1:0];
            res_c = ~diff_w[n];
            res_v = (in1[n-1] != in2[n-1]) && (diff_w[n-1] != in1[n-1]);
         end
         RAND:    res = in1 & in2;
         ROR:     res = in1 | in2;
         RXOR:    res = in1 ^ in2;
         default: res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_hi_d    = out_hi_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (func == RMUL) begin
                  state_d = S_MUL;
               end else begin
                  out_d       = res;
                  out_hi_d    = '0;
                  flags_d[FN] = res[n-1];
                  flags_d[FZ] = (res == '0);
                  flags_d[FC] = res_c;
                  flags_d[FV] = res_v;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (mul_done) begin
               out_d       = mul_prod[n-1:0];
               out_hi_d    = mul_prod[2*n-1:n];
               flags_d[FN] = mul_prod[n-1];
               flags_d[FZ] = (mul_prod[n-1:0] == '0);
               flags_d[FC] = (mul_prod[2*n-1:n] != '0);
               flags_d[FV] = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else if (!mul_busy) begin
               // Multiplier idle without finishing: recover rather than hang.
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign out       = out_q;
   assign out_hi    = out_hi_q;
   assign flags     = flags_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (n=8): hand-computed vectors checked with
// immediate assertions, covering single-cycle ops, multiply timing and reset.
module tb_seq_alu;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in1, in2;
   logic [2:0] alu_func;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out, out_hi;
   logic [3:0] flags;
   logic       out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seq_alu #(.n(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in1       (in1),
      .in2       (in2),
      .alu_func  (alu_func),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_hi    (out_hi),
      .flags     (flags),
      .out_valid (out_valid)
   );

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single edge; leaves time at 1ns after the accept edge.
   task automatic issue(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      alu_func = f;
      in1      = a;
      in2      = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [7:0] e_out,
                               input logic [7:0] e_hi, input logic [3:0] e_flags);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " out"},       32'(out),       32'(e_out));
      check({tag, " out_hi"},    32'(out_hi),    32'(e_hi));
      check({tag, " flags"},     32'(flags),     32'(e_flags));
   endtask

   // Waits for the multiply result, checking in_ready stays low meanwhile.
   task automatic wait_mul(input string tag, output int edges);
      edges = 0;
      while (edges < 20) begin
         check({tag, " in_ready low"}, 32'(in_ready), 32'd0);
         step();
         edges++;
         if (out_valid) break;
      end
      check({tag, " latency"}, 32'(edges), 32'd8);
   endtask

   int edges;
   int pulses;

   initial begin
      reset    = 1'b1;
      in1      = '0;
      in2      = '0;
      alu_func = '0;
      in_valid = 1'b0;
      step();
      step();
      check("reset out",       32'(out),       32'd0);
      check("reset out_hi",    32'(out_hi),    32'd0);
      check("reset flags",     32'(flags),     32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      #1;
      check("reset in_ready",  32'(in_ready),  32'd1);
      step();

      issue(RADD, 8'h43, 8'h30);
      check_result("add43", 8'h73, 8'h00, 4'b0000);
      step();
      check("add43 pulse ends", 32'(out_valid), 32'd0);
      check("add43 out held",   32'(out),       32'h73);

      issue(RSUB, 8'h43, 8'h30);
      check_result("sub43", 8'h13, 8'h00, 4'b0010);
      issue(RSUB, 8'h23, 8'h42);
      check_result("sub borrow", 8'hE1, 8'h00, 4'b1000);
      issue(RADD, 8'h7F, 8'h01);
      check_result("add ovf", 8'h80, 8'h00, 4'b1001);
      issue(RADD, 8'hFF, 8'h01);
      check_result("add carry", 8'h00, 8'h00, 4'b0110);
      issue(RAND, 8'hF0, 8'h3C);
      check_result("and", 8'h30, 8'h00, 4'b0000);
      issue(ROR, 8'h80, 8'h01);
      check_result("or", 8'h81, 8'h00, 4'b1000);
      issue(RXOR, 8'h5A, 8'h5A);
      check_result("xor", 8'h00, 8'h00, 4'b0100);
      issue(RPASSA, 8'hA5, 8'h12);
      check_result("passa", 8'hA5, 8'h00, 4'b1000);
      issue(RPASSB, 8'hA5, 8'h7E);
      check_result("passb", 8'h7E, 8'h00, 4'b0000);
      step();

      // Multiply; operands scrambled during MUL must not matter.
      issue(RMUL, 8'h43, 8'h30);
      in1      = 8'hFF;
      in2      = 8'hFF;
      alu_func = RADD;
      wait_mul("mul43", edges);
      check_result("mul43", 8'h90, 8'h0C, 4'b1010);
      #1;
      check("mul43 in_ready back", 32'(in_ready), 32'd1);
      step();
      check("mul43 pulse ends", 32'(out_valid), 32'd0);
      check("mul43 hi held",    32'(out_hi),    32'h0C);

      issue(RMUL, 8'h23, 8'h42);
      wait_mul("mul23", edges);
      check_result("mul23", 8'h06, 8'h09, 4'b0010);
      step();

      // Back-to-back single-cycle ops.
      alu_func = RADD; in1 = 8'h10; in2 = 8'h20; in_valid = 1'b1;
      step();
      check_result("b2b add", 8'h30, 8'h00, 4'b0000);
      alu_func = RSUB; in1 = 8'h50; in2 = 8'h08;
      step();
      in_valid = 1'b0;
      check_result("b2b sub", 8'h48, 8'h00, 4'b0010);
      step();

      // RADD held valid while a multiply is running.
      issue(RMUL, 8'h03, 8'h05);
      alu_func = RADD; in1 = 8'h11; in2 = 8'h22; in_valid = 1'b1;
      wait_mul("mul blocked", edges);
      check_result("mul blocked", 8'h0F, 8'h00, 4'b0000);
      step();
      in_valid = 1'b0;
      check_result("held add", 8'h33, 8'h00, 4'b0000);
      step();
      check("held add single", 32'(out_valid), 32'd0);

      // Reset at the 4th edge of a multiply.
      issue(RMUL, 8'h43, 8'h30);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst mid out",       32'(out),       32'd0);
      check("rst mid out_hi",    32'(out_hi),    32'd0);
      check("rst mid flags",     32'(flags),     32'd0);
      check("rst mid out_valid", 32'(out_valid), 32'd0);
      check("rst mid in_ready",  32'(in_ready),  32'd1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) pulses++;
      end
      check("rst mid no pulse", 32'(pulses), 32'd0);
      issue(RADD, 8'h01, 8'h01);
      check_result("post rst add", 8'h02, 8'h00, 4'b0000);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
